// File: rtl/mac_host_driver.sv
// Host-side sequencer for a MAC datapath: latches a command's operands, holds them
// for a setup window, pulses trig, waits out the MAC latency and returns the result.
module mac_host_driver #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_din,
  input  logic [7:0]  cmd_win,
  input  logic [7:0]  cmd_bias,
  input  logic        cmd_sign,
  output logic [7:0]  din,
  output logic [7:0]  win0,
  output logic [7:0]  bias0,
  output logic        sign,
  output logic        trig,
  input  logic [7:0]  dout0,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] txn_count
);

  typedef enum logic [2:0] {IDLE, DRIVE, TRIG, WAIT, RESP} state_e;

  // The counter holds "cycles remaining minus one", so it is loaded with N-1.
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LAT_LOAD   = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmd_ready_q, busy_q, trig_q, rsp_valid_q, sign_q;
  logic [7:0]  din_q, win0_q, bias0_q, rsp_data_q;
  logic [15:0] txn_count_q;
  logic        accept, capture, done;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign capture = (state_q == WAIT) && (cnt_q == 4'd0);
  assign done    = (state_q == RESP) && rsp_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = DRIVE;
        cnt_d   = SETUP_LOAD;
      end
      DRIVE: if (cnt_q == 4'd0) state_d = TRIG;
             else               cnt_d   = cnt_q - 4'd1;
      TRIG: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      trig_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      din_q       <= 8'h00;
      win0_q      <= 8'h00;
      bias0_q     <= 8'h00;
      sign_q      <= 1'b0;
      txn_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      trig_q      <= (state_d == TRIG);
      rsp_valid_q <= (state_d == RESP);
      if (accept) begin
        din_q   <= cmd_din;
        win0_q  <= cmd_win;
        bias0_q <= cmd_bias;
        sign_q  <= cmd_sign;
      end
      if (capture) rsp_data_q  <= dout0;
      if (done)    txn_count_q <= txn_count_q + 16'd1;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign trig      = trig_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign din       = din_q;
  assign win0      = win0_q;
  assign bias0     = bias0_q;
  assign sign      = sign_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_mac_host_driver.sv
// Bench for mac_host_driver: two instances (default timing and a 3/5 sweep) share stimulus;
// expectations come from a cycle timeline derived from SETUP_CYC/LATENCY and a MAC model.
module tb_mac_host_driver;

  localparam int SA = 1, LA = 2;
  localparam int SB = 3, LB = 5;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        cmd_valid, cmd_sign, rsp_ready;
  logic [7:0]  cmd_din, cmd_win, cmd_bias, dout0;

  logic        cmd_ready_w [2], busy_w [2], trig_w [2], rsp_valid_w [2], sign_w [2];
  logic [7:0]  din_w [2], win0_w [2], bias0_w [2], rsp_data_w [2];
  logic [15:0] txn_count_w [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 0;
  logic [15:0] exp_count = 16'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_host_driver #(.SETUP_CYC(SA), .LATENCY(LA)) dut_a (
    .clk(clk), .rst(rst_a), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[0]),
    .cmd_din(cmd_din), .cmd_win(cmd_win), .cmd_bias(cmd_bias), .cmd_sign(cmd_sign),
    .din(din_w[0]), .win0(win0_w[0]), .bias0(bias0_w[0]), .sign(sign_w[0]),
    .trig(trig_w[0]), .dout0(dout0), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[0]), .busy(busy_w[0]), .txn_count(txn_count_w[0]));

  mac_host_driver #(.SETUP_CYC(SB), .LATENCY(LB)) dut_b (
    .clk(clk), .rst(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[1]),
    .cmd_din(cmd_din), .cmd_win(cmd_win), .cmd_bias(cmd_bias), .cmd_sign(cmd_sign),
    .din(din_w[1]), .win0(win0_w[1]), .bias0(bias0_w[1]), .sign(sign_w[1]),
    .trig(trig_w[1]), .dout0(dout0), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[1]), .busy(busy_w[1]), .txn_count(txn_count_w[1]));

  function automatic logic [7:0] mac_model(input logic [7:0] d, w, b);
    int r;
    r = int'(d) * int'(w) + int'(b);
    return 8'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_noise();
    cmd_din  = 8'($urandom);
    cmd_win  = 8'($urandom);
    cmd_bias = 8'($urandom);
    cmd_sign = 1'($urandom);
  endtask

  // Runs one command on instance `sel`, checking every cycle against the expected timeline.
  task automatic run_txn(input logic [7:0] d, w, b, input logic s, input int hold,
                         input bit keep_valid, output int acc_cyc);
    int s_cyc, l_cyc, first_resp, done_k;
    logic [7:0] m;
    logic [33:0] got, exp;
    s_cyc      = sel ? SB : SA;
    l_cyc      = sel ? LB : LA;
    first_resp = s_cyc + l_cyc + 2;
    done_k     = first_resp + hold;
    m          = mac_model(d, w, b);
    checks++;
    if (cmd_ready_w[sel] !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: cmd_ready=%b required 1 at cyc %0d", cmd_ready_w[sel], cyc);
    end
    cmd_valid = 1'b1;
    cmd_din = d; cmd_win = w; cmd_bias = b; cmd_sign = s;
    rsp_ready = 1'($urandom);
    dout0 = 8'($urandom);
    acc_cyc = cyc;
    step();
    for (int k = 1; k <= done_k; k++) begin
      got = {trig_w[sel], rsp_valid_w[sel], busy_w[sel], cmd_ready_w[sel],
             din_w[sel], win0_w[sel], bias0_w[sel], sign_w[sel], txn_count_w[sel][4:0]};
      exp = {(k == s_cyc + 1), (k >= first_resp), 1'b1, 1'b0, d, w, b, s, exp_count[4:0]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL txn_cycle%0d: {trig,rv,busy,rdy,din,win,bias,sign,cnt}=%h required %h", k, got, exp);
      end
      if (k >= first_resp) begin
        checks++;
        if (rsp_data_w[sel] !== m) begin
          failures++;
          $display("FAIL rsp_data_cycle%0d: rsp_data=%h required %h", k, rsp_data_w[sel], m);
        end
      end
      cmd_valid = keep_valid ? 1'b1 : 1'($urandom);
      drive_noise();
      rsp_ready = (k < first_resp) ? 1'($urandom) : (k >= done_k);
      dout0     = (k == s_cyc + l_cyc + 1) ? m : (m ^ 8'($urandom_range(1, 255)));
      step();
    end
    exp_count = exp_count + 16'd1;
    got = {trig_w[sel], rsp_valid_w[sel], busy_w[sel], cmd_ready_w[sel],
           din_w[sel], win0_w[sel], bias0_w[sel], sign_w[sel], txn_count_w[sel][4:0]};
    exp = {1'b0, 1'b0, 1'b0, 1'b1, d, w, b, s, exp_count[4:0]};
    checks++;
    if (got !== exp || txn_count_w[sel] !== exp_count) begin
      failures++;
      $display("FAIL txn_done: vec=%h cnt=%h required vec=%h cnt=%h", got, txn_count_w[sel], exp, exp_count);
    end
    cmd_valid = keep_valid;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_valid = 1'b1; rsp_ready = 1'b1; dout0 = 8'hA5;
    drive_noise();
    @(negedge clk);
    repeat (3) step();
    checks++;
    if ({cmd_ready_w[0], busy_w[0], trig_w[0], rsp_valid_w[0], sign_w[0], rsp_data_w[0],
         din_w[0], win0_w[0], bias0_w[0], txn_count_w[0]} !== {5'b10000, 48'h0}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b busy=%b trig=%b rv=%b din=%h cnt=%h required rdy=1 rest 0",
               cmd_ready_w[0], busy_w[0], trig_w[0], rsp_valid_w[0], din_w[0], txn_count_w[0]);
    end
    rst_a = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    step();
    checks++;
    if (cmd_ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b required 1/0", cmd_ready_w[0], busy_w[0]);
    end
    exp_count = 16'h0;
  endtask

  task automatic test_single();
    int t;
    run_txn(8'h12, 8'h03, 8'h05, 1'b0, 0, 1'b0, t);
    checks++;
    if (rsp_data_w[0] !== 8'h3B) begin
      failures++;
      $display("FAIL single_result: rsp_data=%h required 3b", rsp_data_w[0]);
    end
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 6; i++)
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'b0, t);
  endtask

  task automatic test_backpressure();
    int t;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 7, 1'b1, t);
    cmd_valid = 1'b0;
    step();
  endtask

  // Asserts rst during cycle abort_k of a transaction; rdy drives rsp_ready in that cycle.
  task automatic test_reset_mid(input int abort_k, input bit rdy);
    cmd_valid = 1'b1;
    drive_noise();
    step();
    for (int k = 1; k < abort_k; k++) begin
      drive_noise();
      dout0 = 8'($urandom);
      rsp_ready = 1'b0;
      step();
    end
    rst_a = 1'b1;
    rsp_ready = rdy;
    cmd_valid = 1'b1;
    step();
    checks++;
    if ({cmd_ready_w[0], busy_w[0], trig_w[0], rsp_valid_w[0], sign_w[0], rsp_data_w[0],
         din_w[0], win0_w[0], bias0_w[0], txn_count_w[0]} !== {5'b10000, 48'h0}) begin
      failures++;
      $display("FAIL reset_mid_k%0d: rdy=%b busy=%b trig=%b rv=%b din=%h data=%h cnt=%h required rdy=1 rest 0",
               abort_k, cmd_ready_w[0], busy_w[0], trig_w[0], rsp_valid_w[0], din_w[0],
               rsp_data_w[0], txn_count_w[0]);
    end
    rst_a = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_count = 16'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (rsp_valid_w[0] !== 1'b0 || trig_w[0] !== 1'b0 || txn_count_w[0] !== 16'h0) begin
        failures++;
        $display("FAIL reset_mid_quiet_k%0d: rv=%b trig=%b cnt=%h required 0/0/0000",
                 abort_k, rsp_valid_w[0], trig_w[0], txn_count_w[0]);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t [3];
    for (int i = 0; i < 3; i++)
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1, t[i]);
    cmd_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (t[i] - t[i-1] !== SA + LA + 3) begin
        failures++;
        $display("FAIL b2b_spacing%0d: %0d cycles required %0d", i, t[i] - t[i-1], SA + LA + 3);
      end
    end
    checks++;
    if (txn_count_w[0] !== 16'd3) begin
      failures++;
      $display("FAIL b2b_count: txn_count=%h required 0003", txn_count_w[0]);
    end
    step();
  endtask

  task automatic test_wrap();
    int t;
    force dut_a.txn_count_q = 16'hFFFF;
    step();
    release dut_a.txn_count_q;
    exp_count = 16'hFFFF;
    checks++;
    if (txn_count_w[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload: txn_count=%h required ffff", txn_count_w[0]);
    end
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1, 1'b0, t);
    checks++;
    if (txn_count_w[0] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_result: txn_count=%h required 0000", txn_count_w[0]);
    end
  endtask

  task automatic test_param_sweep();
    int t;
    rst_a = 1'b1;
    cmd_valid = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    step();
    sel = 1;
    exp_count = 16'h0;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, t);
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2, 1'b0, t);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_backpressure();
    test_reset_mid(3, 1'b0);
    test_reset_mid(2, 1'b0);
    test_reset_mid(SA + LA + 2, 1'b1);
    test_back_to_back();
    test_wrap();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
